ex_muldiv: RTL
==============

# ex_muldiv

Iterative multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It consumes operand values and the decoded mult/div operation from the ID/EX pipeline register and executes MULT, MULTU, DIV and DIVU over a fixed number of cycles. Results go into the architectural HI/LO registers, and a busy flag tells the hazard unit to stall any dependent MFHI/MFLO or a new mult/div. MTHI/MTLO writes and the HI/LO read ports are also handled here.

## Interface
- No parameters; datapath fixed at 32 bits.
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  launch operation this cycle (from decoded ID/EX control).
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  32  multiplicand / dividend.
- rt_val  in  32  multiplier / divisor.
- flush  in  1  squash the in-flight operation (branch/exception kill).
- mthi  in  1  write rs_val to HI.
- mtlo  in  1  write rs_val to LO.
- hi_out  out  32  current HI register.
- lo_out  out  32  current LO register.
- busy  out  1  operation in flight; hazard unit stalls on it.
- done  out  1  one-cycle pulse; HI/LO just updated by a completed operation.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 and flush=0: latch absolute values of both operands. Signed ops use two's-complement magnitude; unsigned ops pass operands unchanged.
  - Latch the result-sign flags, clear the 6-bit counter, go to CALC.
- CALC: 32 iterations, one per cycle, counter 0..31. On count 31, go to FIX.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; 32-bit remainder with carry bit, 32-bit quotient.
- FIX: apply signs.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient. Return to IDLE and pulse done.
- Divide by zero: CALC still runs all 32 cycles. The final result is forced to HI = original rs_val, LO = 32'hFFFF_FFFF for both DIV and DIVU.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0. This falls out of the magnitude arithmetic; no special case.
- start while busy: ignored.
- mthi/mtlo:
  - Accepted only in IDLE with start=0; take effect at the next edge.
  - When both are asserted, both registers are written.
  - Ignored when busy=1 or when start=1 in the same cycle.
- flush:
  - In CALC or FIX: return to IDLE next edge with HI/LO unchanged and no done pulse.
  - In IDLE: blocks start.
- Flush takes priority over FIX completion.
- Reset, including mid-operation: state IDLE; HI, LO, accumulator, counter, busy and done all 0.

## Timing
- start sampled at edge N, so busy=1 from N through N+33.
- CALC occupies edges N+1..N+32; FIX edge is N+33.
- After edge N+33: HI/LO hold the new result, done=1 and busy=0 for one cycle.
- A new start is accepted at edge N+34, which gives 34-cycle back-to-back throughput.
- Latency is identical for every op and operand value, including divide by zero.
- hi_out/lo_out are direct register outputs with no combinational path from inputs.
- busy is registered and decoded from state: busy = (state != IDLE).

## Configuration
- MULDIV_DIV_EN defined: all four ops supported as above.
- MULDIV_DIV_EN undefined:
  - Divide datapath is removed.
  - start with op[1]=1 is ignored: state stays IDLE, busy stays 0, HI/LO unchanged, no done pulse.
  - MULT/MULTU timing is unchanged.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001; done exactly 34 cycles after start; busy high for 34 cycles.
- MULT -7 × 3 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; DIV -7 / 2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIVU 100 / 0 -> HI=100, LO=0xFFFF_FFFF after 34 cycles; DIV 0x8000_0000 / -1 -> LO=0x8000_0000, HI=0.
- flush at cycle 10 of a MULT with HI/LO preloaded via mthi=0x1234, mtlo=0x5678 -> busy drops next cycle, no done, HI/LO still 0x1234/0x5678.
- mthi/start pulsed while busy and reset at cycle 20 -> both ignored during busy; after reset all outputs 0 and state IDLE; new start accepted the next cycle.
- Build without MULDIV_DIV_EN, issue DIVU 10/3 -> busy stays 0, no done, HI/LO unchanged; MULTU 6×7 still gives LO=42 in 34 cycles.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
// Optional macro MULDIV_DIV_EN adds the restoring divider; without it only multiplies run.
module ex_muldiv (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        w_launch;
  logic        w_finish;
  logic        w_opOk;
  logic        w_signedOp;
  logic        w_rsNeg;
  logic        w_rtNeg;
  logic [31:0] w_rsMag;
  logic [31:0] w_rtMag;
  logic [63:0] r_acc;
  logic [63:0] w_accNext;
  logic [63:0] w_mulStep;
  logic [63:0] w_prod;
  logic [32:0] w_mulSum;
  logic [31:0] r_operand;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] w_fixHi;
  logic [31:0] w_fixLo;
  logic [5:0]  r_count;
  logic        r_negResult;
  logic        r_done;

`ifdef MULDIV_DIV_EN
  logic        r_isDiv;
  logic        r_negRem;
  logic        r_divZero;
  logic [32:0] w_divDiff;
  logic [63:0] w_divStep;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
`endif

  assign w_signedOp = ~op[0];
  assign w_rsNeg    = w_signedOp & rs_val[31];
  assign w_rtNeg    = w_signedOp & rt_val[31];
  assign w_rsMag    = w_rsNeg ? (~rs_val + 32'd1) : rs_val;
  assign w_rtMag    = w_rtNeg ? (~rt_val + 32'd1) : rt_val;

`ifdef MULDIV_DIV_EN
  assign w_opOk = 1'b1;
`else
  assign w_opOk = ~op[1];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Flush wins over both launch and FIX completion.
  always_comb begin
    w_nextState = r_state;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !flush && w_opOk) begin
          w_launch    = 1'b1;
          w_nextState = CALC;
        end
      end
      CALC: begin
        if (flush)                  w_nextState = IDLE;
        else if (r_count == 6'd31)  w_nextState = FIX;
      end
      FIX: begin
        w_nextState = IDLE;
        if (!flush) w_finish = 1'b1;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Multiply: r_acc = {partial sum, remaining multiplier bits}, shifted right each step.
  assign w_mulSum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_operand} : 33'd0);
  assign w_mulStep = {w_mulSum, r_acc[31:1]};
  assign w_prod    = r_negResult ? (~r_acc + 64'd1) : r_acc;

`ifdef MULDIV_DIV_EN
  // Divide: r_acc = {remainder, quotient}; a zero divisor leaves |dividend| in the remainder.
  assign w_divDiff = r_acc[63:31] - {1'b0, r_operand};
  assign w_divStep = w_divDiff[32] ? {r_acc[62:0], 1'b0}
                                   : {w_divDiff[31:0], r_acc[30:0], 1'b1};
  assign w_quo     = r_divZero   ? 32'hFFFF_FFFF
                   : r_negResult ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem     = r_negRem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
  assign w_accNext = r_isDiv ? w_divStep : w_mulStep;
  assign w_fixHi   = r_isDiv ? w_rem : w_prod[63:32];
  assign w_fixLo   = r_isDiv ? w_quo : w_prod[31:0];
`else
  assign w_accNext = w_mulStep;
  assign w_fixHi   = w_prod[63:32];
  assign w_fixLo   = w_prod[31:0];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc       <= 64'd0;
      r_operand   <= 32'd0;
      r_count     <= 6'd0;
      r_negResult <= 1'b0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_done      <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_isDiv     <= 1'b0;
      r_negRem    <= 1'b0;
      r_divZero   <= 1'b0;
`endif
    end else begin
      r_done <= w_finish;
      if (w_launch) begin
        r_count     <= 6'd0;
        r_negResult <= w_rsNeg ^ w_rtNeg;
`ifdef MULDIV_DIV_EN
        r_isDiv     <= op[1];
        r_negRem    <= w_rsNeg;
        r_divZero   <= (rt_val == 32'd0);
        r_acc       <= {32'd0, op[1] ? w_rsMag : w_rtMag};
        r_operand   <= op[1] ? w_rtMag : w_rsMag;
`else
        r_acc       <= {32'd0, w_rtMag};
        r_operand   <= w_rsMag;
`endif
      end else if (r_state == CALC) begin
        r_acc   <= w_accNext;
        r_count <= r_count + 6'd1;
      end
      if (w_finish) begin
        r_hi <= w_fixHi;
        r_lo <= w_fixLo;
      end else if (r_state == IDLE && !start) begin
        if (mthi) r_hi <= rs_val;
        if (mtlo) r_lo <= rs_val;
      end
    end
  end

  assign hi_out = r_hi;
  assign lo_out = r_lo;
  assign busy   = (r_state != IDLE);
  assign done   = r_done;

endmodule
